// File: rtl/id_pkg.sv
// Shared encodings for the MIPS decode stage: branch compare modes, compare-operand
// forwarding selects and the default control-word bit positions.
package id_pkg;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_NE  = 2'b01,
    BR_LEZ = 2'b10,
    BR_GTZ = 2'b11
  } br_mode_e;

  // Encoding 2'b11 is not named; the comparator treats it as FWD_RF.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam int MEMREAD_BIT_DEF  = 7;
  localparam int REGWRITE_BIT_DEF = 13;

endpackage

// File: rtl/regfile_bypass.sv
// General-purpose register file: two async read ports plus a debug port, register 0
// hardwired to zero, and write-first bypass of the WB write on every read port.
module regfile_bypass #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  input  logic [REG_ADDR_W-1:0] i_raddr_dbg,
  output logic [DATA_W-1:0]     o_rdata_a,
  output logic [DATA_W-1:0]     o_rdata_b,
  output logic [DATA_W-1:0]     o_rdata_dbg
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_live;

  assign wr_live = i_we && (i_waddr != '0);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and start from a full default so
    // every path assigns every output; a missing default would infer a latch.
    regs_d = regs_q;
    if (wr_live) regs_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: the array is cleared on reset because software may read a register it
    // never wrote and must see 0; this rules out mapping it onto a RAM macro.
    if (i_reset) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  assign o_rdata_a   = (i_raddr_a == '0)   ? '0 :
                       (wr_live && i_raddr_a == i_waddr)   ? i_wdata : regs_q[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b == '0)   ? '0 :
                       (wr_live && i_raddr_b == i_waddr)   ? i_wdata : regs_q[i_raddr_b];
  assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 :
                       (wr_live && i_raddr_dbg == i_waddr) ? i_wdata : regs_q[i_raddr_dbg];

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS decode stage: register file, branch resolution in ID, hazard detection and the
// ID/EX pipeline register with stall, flush and debug-enable control.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CTRL_W       = 18,
  parameter int MEMREAD_BIT  = MEMREAD_BIT_DEF,
  parameter int REGWRITE_BIT = REGWRITE_BIT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [31:0]           i_instr_D,
  input  logic [DATA_W-1:0]     i_npc_D,
  input  logic [CTRL_W-1:0]     i_ctrl_D,
  input  logic                  i_branch_D,
  input  logic [1:0]            i_br_mode_D,
  input  logic [1:0]            i_fwd_a_D,
  input  logic [1:0]            i_fwd_b_D,
  input  logic [DATA_W-1:0]     i_alu_result_M,
  input  logic [REG_ADDR_W-1:0] i_dest_M,
  input  logic                  i_mem_read_M,
  input  logic                  i_reg_write_W,
  input  logic [REG_ADDR_W-1:0] i_waddr_W,
  input  logic [DATA_W-1:0]     i_wdata_W,
  input  logic [REG_ADDR_W-1:0] i_dest_E,
  input  logic                  i_flush_E,
  input  logic [REG_ADDR_W-1:0] i_debug_addr,
  output logic [DATA_W-1:0]     o_reg,
  output logic                  o_stall_D,
  output logic                  o_pc_src_D,
  output logic [DATA_W-1:0]     o_branch_addr_D,
  output logic [DATA_W-1:0]     o_jump_addr_D,
  output logic [DATA_W-1:0]     o_rd1_E,
  output logic [DATA_W-1:0]     o_rd2_E,
  output logic [DATA_W-1:0]     o_imm_E,
  output logic [DATA_W-1:0]     o_npc_E,
  output logic [REG_ADDR_W-1:0] o_rs_E,
  output logic [REG_ADDR_W-1:0] o_rt_E,
  output logic [REG_ADDR_W-1:0] o_rd_E,
  output logic [CTRL_W-1:0]     o_ctrl_E
);

  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rd1, rd2, imm_ext;
  logic [DATA_W-1:0]     op_a, op_b;
  logic                  cond;
  logic                  load_use, br_on_ex, br_on_mem;
  logic                  unused_opcode;

  assign rs            = i_instr_D[25:21];
  assign rt            = i_instr_D[20:16];
  assign rd            = i_instr_D[15:11];
  assign imm_ext       = {{(DATA_W-16){i_instr_D[15]}}, i_instr_D[15:0]};
  assign unused_opcode = ^i_instr_D[31:26];

  regfile_bypass #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we       (i_reg_write_W && i_enable),
    .i_waddr    (i_waddr_W),
    .i_wdata    (i_wdata_W),
    .i_raddr_a  (rs),
    .i_raddr_b  (rt),
    .i_raddr_dbg(i_debug_addr),
    .o_rdata_a  (rd1),
    .o_rdata_b  (rd2),
    .o_rdata_dbg(o_reg)
  );

  always_comb begin
    op_a = rd1;
    op_b = rd2;
    case (i_fwd_a_D)
      FWD_MEM: op_a = i_alu_result_M;
      FWD_WB:  op_a = i_wdata_W;
      default: op_a = rd1;
    endcase
    case (i_fwd_b_D)
      FWD_MEM: op_b = i_alu_result_M;
      FWD_WB:  op_b = i_wdata_W;
      default: op_b = rd2;
    endcase
  end

  // LEZ/GTZ test only the sign bit and zero-ness of op_a.
  always_comb begin
    cond = 1'b0;
    case (br_mode_e'(i_br_mode_D))
      BR_EQ:  cond = (op_a == op_b);
      BR_NE:  cond = (op_a != op_b);
      BR_LEZ: cond = op_a[DATA_W-1] || (op_a == '0);
      BR_GTZ: cond = !op_a[DATA_W-1] && (op_a != '0);
      default: cond = 1'b0;
    endcase
  end

  function automatic logic idx_hit(input logic [REG_ADDR_W-1:0] idx,
                                   input logic [REG_ADDR_W-1:0] a,
                                   input logic [REG_ADDR_W-1:0] b);
    return (idx != '0) && ((idx == a) || (idx == b));
  endfunction

  assign load_use  = o_ctrl_E[MEMREAD_BIT] && idx_hit(o_rt_E, rs, rt);
  assign br_on_ex  = i_branch_D && o_ctrl_E[REGWRITE_BIT] && idx_hit(i_dest_E, rs, rt);
  assign br_on_mem = i_branch_D && i_mem_read_M && idx_hit(i_dest_M, rs, rt);
  assign o_stall_D = i_enable && (load_use || br_on_ex || br_on_mem);

  assign o_pc_src_D      = i_branch_D && cond && !o_stall_D && i_enable;
  assign o_branch_addr_D = i_npc_D + (imm_ext << 2);
  assign o_jump_addr_D   = {i_npc_D[DATA_W-1:DATA_W-4], i_instr_D[25:0], 2'b00};

  logic [DATA_W-1:0]     rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, npc_d, npc_q;
  logic [REG_ADDR_W-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
  logic [CTRL_W-1:0]     ctrl_d, ctrl_q;

  // A bubble only clears the control word; the data fields are don't-care downstream.
  always_comb begin
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    npc_d  = npc_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    ctrl_d = ctrl_q;
    if (i_enable) begin
      rd1_d  = rd1;
      rd2_d  = rd2;
      imm_d  = imm_ext;
      npc_d  = i_npc_D;
      rs_d   = rs;
      rt_d   = rt;
      rd_d   = rd;
      ctrl_d = (i_flush_E || o_stall_D) ? '0 : i_ctrl_D;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (i_reset) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      npc_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      npc_q  <= npc_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign o_rd1_E  = rd1_q;
  assign o_rd2_E  = rd2_q;
  assign o_imm_E  = imm_q;
  assign o_npc_E  = npc_q;
  assign o_rs_E   = rs_q;
  assign o_rt_E   = rt_q;
  assign o_rd_E   = rd_q;
  assign o_ctrl_E = ctrl_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: a reference register-file model feeds a
// scoreboard of expected ID/EX contents; combinational outputs are checked inline.
module tb_id_stage_pipelined;

  logic        i_clk, i_reset, i_enable;
  logic [31:0] i_instr_D, i_npc_D;
  logic [17:0] i_ctrl_D;
  logic        i_branch_D;
  logic [1:0]  i_br_mode_D, i_fwd_a_D, i_fwd_b_D;
  logic [31:0] i_alu_result_M;
  logic [4:0]  i_dest_M;
  logic        i_mem_read_M, i_reg_write_W;
  logic [4:0]  i_waddr_W;
  logic [31:0] i_wdata_W;
  logic [4:0]  i_dest_E;
  logic        i_flush_E;
  logic [4:0]  i_debug_addr;
  logic [31:0] o_reg;
  logic        o_stall_D, o_pc_src_D;
  logic [31:0] o_branch_addr_D, o_jump_addr_D;
  logic [31:0] o_rd1_E, o_rd2_E, o_imm_E, o_npc_E;
  logic [4:0]  o_rs_E, o_rt_E, o_rd_E;
  logic [17:0] o_ctrl_E;

  id_stage_pipelined dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_instr_D(i_instr_D), .i_npc_D(i_npc_D), .i_ctrl_D(i_ctrl_D),
    .i_branch_D(i_branch_D), .i_br_mode_D(i_br_mode_D),
    .i_fwd_a_D(i_fwd_a_D), .i_fwd_b_D(i_fwd_b_D),
    .i_alu_result_M(i_alu_result_M), .i_dest_M(i_dest_M), .i_mem_read_M(i_mem_read_M),
    .i_reg_write_W(i_reg_write_W), .i_waddr_W(i_waddr_W), .i_wdata_W(i_wdata_W),
    .i_dest_E(i_dest_E), .i_flush_E(i_flush_E), .i_debug_addr(i_debug_addr),
    .o_reg(o_reg), .o_stall_D(o_stall_D), .o_pc_src_D(o_pc_src_D),
    .o_branch_addr_D(o_branch_addr_D), .o_jump_addr_D(o_jump_addr_D),
    .o_rd1_E(o_rd1_E), .o_rd2_E(o_rd2_E), .o_imm_E(o_imm_E), .o_npc_E(o_npc_E),
    .o_rs_E(o_rs_E), .o_rt_E(o_rt_E), .o_rd_E(o_rd_E), .o_ctrl_E(o_ctrl_E)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, npc;
    logic [4:0]  rs, rt, rd;
    logic [17:0] ctrl;
  } ex_t;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  logic [31:0] mregs [32];
  ex_t         sb_q [$];
  ex_t         last_issued;

  localparam logic [17:0] CTRL_LOAD = 18'h02080;
  localparam logic [17:0] CTRL_ALU  = 18'h00003;
  localparam logic [17:0] CTRL_BR   = 18'h00004;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (i_reg_write_W && i_enable && i_waddr_W == a) return i_wdata_W;
    return mregs[a];
  endfunction

  task automatic tick();
    if (i_reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (i_enable && i_reg_write_W && i_waddr_W != 5'd0) begin
      mregs[i_waddr_W] = i_wdata_W;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_instr_D = '0; i_npc_D = '0; i_ctrl_D = '0; i_branch_D = 0; i_br_mode_D = 2'b00;
    i_fwd_a_D = 2'b00; i_fwd_b_D = 2'b00; i_alu_result_M = '0; i_dest_M = '0;
    i_mem_read_M = 0; i_reg_write_W = 0; i_waddr_W = '0; i_wdata_W = '0;
    i_dest_E = '0; i_flush_E = 0; i_debug_addr = '0;
  endtask

  task automatic push_expected();
    ex_t e;
    e.rd1  = model_read(i_instr_D[25:21]);
    e.rd2  = model_read(i_instr_D[20:16]);
    e.imm  = {{16{i_instr_D[15]}}, i_instr_D[15:0]};
    e.npc  = i_npc_D;
    e.rs   = i_instr_D[25:21];
    e.rt   = i_instr_D[20:16];
    e.rd   = i_instr_D[15:11];
    e.ctrl = i_ctrl_D;
    sb_q.push_back(e);
    last_issued = e;
  endtask

  task automatic compare_fields(input string p, input ex_t e);
    check({p, "_rd1"},  o_rd1_E, e.rd1);
    check({p, "_rd2"},  o_rd2_E, e.rd2);
    check({p, "_imm"},  o_imm_E, e.imm);
    check({p, "_npc"},  o_npc_E, e.npc);
    check({p, "_rs"},   {27'd0, o_rs_E}, {27'd0, e.rs});
    check({p, "_rt"},   {27'd0, o_rt_E}, {27'd0, e.rt});
    check({p, "_rd"},   {27'd0, o_rd_E}, {27'd0, e.rd});
    check({p, "_ctrl"}, {14'd0, o_ctrl_E}, {14'd0, e.ctrl});
  endtask

  task automatic compare_expected(input string p);
    if (sb_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", p);
    end else begin
      compare_fields(p, sb_q.pop_front());
    end
  endtask

  initial begin
    idle();
    i_reset = 1; i_enable = 1;
    tick(); tick();
    check("rst_ctrl",  {14'd0, o_ctrl_E}, 32'd0);
    check("rst_rd1",   o_rd1_E, 32'd0);
    check("rst_npc",   o_npc_E, 32'd0);
    check("rst_stall", {31'd0, o_stall_D}, 32'd0);
    check("rst_pcsrc", {31'd0, o_pc_src_D}, 32'd0);
    i_reset = 0;

    // 1: WB writes r5 while ID reads r5
    i_instr_D = mk(6'h00, 5'd5, 5'd0, 16'h2820); i_ctrl_D = CTRL_ALU; i_npc_D = 32'h40;
    i_reg_write_W = 1; i_waddr_W = 5'd5; i_wdata_W = 32'h1234; i_debug_addr = 5'd5;
    #1;
    check("t1_dbg_bypass", o_reg, 32'h1234);
    check("t1_stall", {31'd0, o_stall_D}, 32'd0);
    push_expected(); tick(); compare_expected("t1");
    i_reg_write_W = 0; #1;
    check("t1_dbg_stored", o_reg, 32'h1234);

    // 2: load r3 then use r3 (with a concurrent flush)
    i_instr_D = mk(6'h23, 5'd0, 5'd3, 16'h0010); i_ctrl_D = CTRL_LOAD; i_npc_D = 32'h44;
    push_expected(); tick(); compare_expected("t2_ld");
    i_dest_E = 5'd3;
    i_instr_D = mk(6'h00, 5'd3, 5'd6, 16'h3820); i_ctrl_D = CTRL_ALU; i_npc_D = 32'h48;
    i_flush_E = 1; #1;
    check("t2_stall_on", {31'd0, o_stall_D}, 32'd1);
    tick();
    i_flush_E = 0; i_dest_E = 5'd0;
    check("t2_bubble", {14'd0, o_ctrl_E}, 32'd0);
    #1;
    check("t2_stall_off", {31'd0, o_stall_D}, 32'd0);
    push_expected(); tick(); compare_expected("t2_use");

    // 3: load r4 then BEQ r4,r0: two stall cycles, resolve via WB forward
    i_instr_D = mk(6'h23, 5'd0, 5'd4, 16'h0008); i_ctrl_D = CTRL_LOAD; i_npc_D = 32'h4C;
    push_expected(); tick(); compare_expected("t3_ld");
    i_dest_E = 5'd4;
    i_instr_D = mk(6'h04, 5'd4, 5'd0, 16'h0003); i_ctrl_D = CTRL_BR; i_npc_D = 32'h200;
    i_branch_D = 1; i_br_mode_D = 2'b00;
    #1;
    check("t3_stall_c1", {31'd0, o_stall_D}, 32'd1);
    check("t3_pcsrc_c1", {31'd0, o_pc_src_D}, 32'd0);
    tick();
    i_dest_E = 5'd0; i_dest_M = 5'd4; i_mem_read_M = 1;
    #1;
    check("t3_bubble", {14'd0, o_ctrl_E}, 32'd0);
    check("t3_stall_c2", {31'd0, o_stall_D}, 32'd1);
    check("t3_pcsrc_c2", {31'd0, o_pc_src_D}, 32'd0);
    tick();
    i_dest_M = 5'd0; i_mem_read_M = 0;
    i_reg_write_W = 1; i_waddr_W = 5'd4; i_wdata_W = 32'd0; i_fwd_a_D = 2'b10;
    #1;
    check("t3_stall_c3", {31'd0, o_stall_D}, 32'd0);
    check("t3_pcsrc_c3", {31'd0, o_pc_src_D}, 32'd1);
    check("t3_baddr",    o_branch_addr_D, 32'h20C);
    push_expected(); tick(); compare_expected("t3_br");
    i_reg_write_W = 0; i_fwd_a_D = 2'b00;

    // 4: BNE/BEQ with equal forwarded operands, negative offset, wrap, fwd 11, jump
    i_instr_D = mk(6'h05, 5'd1, 5'd2, 16'hFFFF); i_npc_D = 32'h100;
    i_fwd_a_D = 2'b01; i_alu_result_M = 32'h5; i_fwd_b_D = 2'b10; i_wdata_W = 32'h5;
    i_br_mode_D = 2'b01; #1;
    check("t4_bne_pcsrc", {31'd0, o_pc_src_D}, 32'd0);
    check("t4_bne_baddr", o_branch_addr_D, 32'hFC);
    i_br_mode_D = 2'b00; #1;
    check("t4_beq_pcsrc", {31'd0, o_pc_src_D}, 32'd1);
    check("t4_beq_baddr", o_branch_addr_D, 32'hFC);
    i_fwd_a_D = 2'b11; i_fwd_b_D = 2'b00;
    i_instr_D = mk(6'h04, 5'd5, 5'd0, 16'h0000); #1;
    check("t4_fwd11_ne", {31'd0, o_pc_src_D}, 32'd0);
    i_instr_D = mk(6'h04, 5'd5, 5'd5, 16'h0000); #1;
    check("t4_fwd11_eq", {31'd0, o_pc_src_D}, 32'd1);
    i_npc_D = 32'hFFFF_FFFC; i_instr_D = mk(6'h04, 5'd1, 5'd2, 16'h0002); #1;
    check("t4_baddr_wrap", o_branch_addr_D, 32'h4);
    i_npc_D = 32'hA000_0000; i_instr_D = {6'h02, 26'h3FF_FFFF}; #1;
    check("t4_jaddr", o_jump_addr_D, 32'hAFFF_FFFC);

    // 5: LEZ/GTZ on forwarded operand a
    i_instr_D = mk(6'h07, 5'd1, 5'd2, 16'h0000); i_npc_D = 32'h300;
    i_fwd_a_D = 2'b01; i_fwd_b_D = 2'b00; i_alu_result_M = 32'h8000_0000;
    i_br_mode_D = 2'b11; #1;
    check("t5_gtz_neg", {31'd0, o_pc_src_D}, 32'd0);
    i_br_mode_D = 2'b10; #1;
    check("t5_lez_neg", {31'd0, o_pc_src_D}, 32'd1);
    i_alu_result_M = 32'd0; #1;
    check("t5_lez_zero", {31'd0, o_pc_src_D}, 32'd1);
    i_br_mode_D = 2'b11; #1;
    check("t5_gtz_zero", {31'd0, o_pc_src_D}, 32'd0);
    i_alu_result_M = 32'd1; #1;
    check("t5_gtz_pos", {31'd0, o_pc_src_D}, 32'd1);

    // 6: debug freeze, then reset while frozen
    idle();
    i_instr_D = mk(6'h23, 5'd5, 5'd7, 16'h1111); i_ctrl_D = CTRL_LOAD; i_npc_D = 32'h500;
    push_expected(); tick(); compare_expected("t6_ld");
    i_enable = 0;
    i_reg_write_W = 1; i_waddr_W = 5'd9; i_wdata_W = 32'hDEAD_BEEF;
    i_instr_D = mk(6'h04, 5'd7, 5'd0, 16'h2222); i_ctrl_D = CTRL_ALU; i_npc_D = 32'h504;
    i_branch_D = 1; i_br_mode_D = 2'b00; #1;
    check("t6_stall_frozen", {31'd0, o_stall_D}, 32'd0);
    check("t6_pcsrc_frozen", {31'd0, o_pc_src_D}, 32'd0);
    tick(); tick();
    compare_fields("t6_hold", last_issued);
    i_reg_write_W = 0; i_debug_addr = 5'd9; #1;
    check("t6_no_write", o_reg, model_read(5'd9));
    i_branch_D = 0; i_enable = 1; #1;
    check("t6_stall_live", {31'd0, o_stall_D}, 32'd1);
    i_reset = 1; i_enable = 0;
    tick();
    compare_fields("t6_rst", '0);
    i_reset = 0; i_enable = 1; i_debug_addr = 5'd5; #1;
    check("t6_stall_cleared", {31'd0, o_stall_D}, 32'd0);
    check("t6_rf_cleared", o_reg, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
